// File: rtl/spi_peripheral.sv
// SPI mode-0 peripheral: oversamples host sclk/csn/mosi in the clk domain, shifts
// fixed WIDTH-bit words MSB first, and exposes a one-entry TX holding register.
module spi_peripheral #(
  parameter int              WIDTH       = 16,
  parameter logic [WIDTH-1:0] IDLE_WORD  = '0,
  parameter int              SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             csn,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             tx_underrun,
  output logic             aborted
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    WAIT_DESELECT,
    IDLE,
    ACTIVE
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] csn_sync_q, csn_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   csn_prev_q, csn_prev_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]       rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0]       tx_shift_q, tx_shift_d;
  logic                   reload_q, reload_d;
  logic [WIDTH-1:0]       hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic [WIDTH-1:0]       rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   underrun_q, underrun_d;
  logic                   aborted_q, aborted_d;
  logic                   miso_oe_q, miso_oe_d;
  logic                   miso_q, miso_d;
  logic                   busy_q, busy_d;

  logic sclk_s, csn_s, mosi_s;
  logic sclk_rise, sclk_fall, csn_rise, csn_fall;
  logic load;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign csn_s     = csn_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign csn_rise  = csn_s & ~csn_prev_q;
  assign csn_fall  = ~csn_s & csn_prev_q;

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves one unassigned (no latches).
    state_d     = state_q;
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    csn_sync_d  = {csn_sync_q[SYNC_STAGES-2:0], csn};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sclk_prev_d = sclk_s;
    csn_prev_d  = csn_s;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    reload_d    = reload_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    aborted_d   = 1'b0;
    miso_oe_d   = miso_oe_q;
    busy_d      = busy_q;
    load        = 1'b0;

    case (state_q)
      WAIT_DESELECT: begin
        if (csn_s) state_d = IDLE;
      end
      IDLE: begin
        if (csn_fall) begin
          load      = 1'b1;
          bit_cnt_d = '0;
          reload_d  = 1'b0;
          miso_oe_d = 1'b1;
          busy_d    = 1'b1;
          state_d   = ACTIVE;
        end
      end
      ACTIVE: begin
        // Deselect takes priority over any sclk edge seen in the same cycle.
        if (csn_rise) begin
          aborted_d = (bit_cnt_q != '0);
          reload_d  = 1'b0;
          bit_cnt_d = '0;
          miso_oe_d = 1'b0;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[WIDTH-2:0], mosi_s};
          if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
            rx_data_d  = {rx_shift_q[WIDTH-2:0], mosi_s};
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
            reload_d   = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (sclk_fall) begin
          if (reload_q) begin
            load     = 1'b1;
            reload_d = 1'b0;
          end else begin
            tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
          end
        end
      end
      default: state_d = WAIT_DESELECT;
    endcase

    if (load) begin
      if (hold_full_q) begin
        tx_shift_d  = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_shift_d = IDLE_WORD;
        underrun_d = 1'b1;
      end
    end

    // A write needs an empty register, so it never collides with a consuming load.
    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    miso_d = miso_oe_d & tx_shift_d[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_DESELECT;
      sclk_sync_q <= '0;
      // NOTE: csn sync resets to "selected" so a host already mid-frame must
      // visibly deselect before we can join a transaction.
      csn_sync_q  <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      csn_prev_q  <= 1'b0;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      reload_q    <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      aborted_q   <= 1'b0;
      miso_oe_q   <= 1'b0;
      miso_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      csn_sync_q  <= csn_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      csn_prev_q  <= csn_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      reload_q    <= reload_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      aborted_q   <= aborted_d;
      miso_oe_q   <= miso_oe_d;
      miso_q      <= miso_d;
      busy_q      <= busy_d;
    end
  end

  assign miso        = miso_q;
  assign miso_oe     = miso_oe_q;
  assign tx_ready    = ~hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = busy_q;
  assign tx_underrun = underrun_q;
  assign aborted     = aborted_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: a mode-0 host model driving sclk at clk/4 with
// minimum csn setup, plus a monitor collecting rx words and strobe counts.
module tb_spi_peripheral;

  localparam int SETUP = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        sclk, csn, mosi;
  logic        miso, miso_oe;
  logic [15:0] tx_data;
  logic        tx_valid, tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid, busy, tx_underrun, aborted;

  int checks = 0;
  int errors = 0;

  logic [15:0] rx_q[$];
  int          under_cnt = 0;
  int          abort_cnt = 0;
  bit          oe_seen   = 1'b0;

  logic [15:0] m0, m1, exp_tx, exp_rx;

  spi_peripheral #(
    .WIDTH      (16),
    .IDLE_WORD  (16'h0000),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sclk       (sclk),
    .csn        (csn),
    .mosi       (mosi),
    .miso       (miso),
    .miso_oe    (miso_oe),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .busy       (busy),
    .tx_underrun(tx_underrun),
    .aborted    (aborted)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid)    rx_q.push_back(rx_data);
    if (tx_underrun) under_cnt++;
    if (aborted)     abort_cnt++;
    if (miso_oe)     oe_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_tx(input logic [15:0] w);
    int n;
    n = 0;
    @(negedge clk);
    while (!tx_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("tx_ready_wait", {31'b0, tx_ready}, 32'd1);
    tx_data  = w;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic frame_start(input logic [15:0] w);
    @(negedge clk);
    csn  = 1'b0;
    mosi = w[15];
    repeat (SETUP - 2) @(negedge clk);
  endtask

  // Host samples miso at the end of the high phase, then drops sclk.
  task automatic shift_bits(input logic [15:0] w, input int n, input bit close,
                            output logic [15:0] got);
    got  = '0;
    mosi = w[15];
    for (int i = 0; i < n; i++) begin
      repeat (2) @(negedge clk);
      sclk = 1'b1;
      repeat (2) @(negedge clk);
      got  = {got[14:0], miso};
      sclk = 1'b0;
      if (i == n - 1) begin
        if (close) csn = 1'b1;
      end else begin
        mosi = w[14-i];
      end
    end
  endtask

  task automatic gap();
    repeat (6) @(negedge clk);
  endtask

  task automatic xfer(input logic [15:0] mo, output logic [15:0] mi);
    frame_start(mo);
    shift_bits(mo, 16, 1'b1, mi);
    gap();
  endtask

  task automatic expect_rx(input string tag, input logic [15:0] exp);
    check({tag, "_rx_cnt"}, rx_q.size(), 32'd1);
    if (rx_q.size() > 0) check({tag, "_rx_data"}, {16'b0, rx_q.pop_front()}, {16'b0, exp});
    rx_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; csn = 1'b1; sclk = 1'b0; mosi = 1'b0;
    tx_valid = 1'b0; tx_data = '0;
    repeat (4) @(negedge clk);
    check("rst_miso",     {31'b0, miso},        32'd0);
    check("rst_miso_oe",  {31'b0, miso_oe},     32'd0);
    check("rst_tx_ready", {31'b0, tx_ready},    32'd1);
    check("rst_rx_data",  {16'b0, rx_data},     32'd0);
    check("rst_rx_valid", {31'b0, rx_valid},    32'd0);
    check("rst_busy",     {31'b0, busy},        32'd0);
    check("rst_underrun", {31'b0, tx_underrun}, 32'd0);
    check("rst_aborted",  {31'b0, aborted},     32'd0);
    rst = 1'b0;
    gap();
    rx_q.delete(); under_cnt = 0;

    // Single word
    push_tx(16'h5A3C);
    xfer(16'hA503, m0);
    check("single_miso", {16'b0, m0}, 32'h5A3C);
    expect_rx("single", 16'hA503);
    check("single_tx_ready", {31'b0, tx_ready}, 32'd1);
    check("single_underrun", under_cnt, 32'd0);

    // Back-to-back words in one frame, refilling once the first is loaded
    under_cnt = 0;
    push_tx(16'h1234);
    fork
      begin
        frame_start(16'h0001);
        shift_bits(16'h0001, 16, 1'b0, m0);
        shift_bits(16'h8000, 16, 1'b1, m1);
      end
      push_tx(16'hBEEF);
    join
    gap();
    check("b2b_miso0", {16'b0, m0}, 32'h1234);
    check("b2b_miso1", {16'b0, m1}, 32'hBEEF);
    check("b2b_rx_cnt", rx_q.size(), 32'd2);
    if (rx_q.size() > 0) check("b2b_rx0", {16'b0, rx_q.pop_front()}, 32'h0001);
    if (rx_q.size() > 0) check("b2b_rx1", {16'b0, rx_q.pop_front()}, 32'h8000);
    rx_q.delete();
    check("b2b_underrun", under_cnt, 32'd0);

    // Underrun
    under_cnt = 0;
    xfer(16'hFFFF, m0);
    check("under_miso", {16'b0, m0}, 32'h0000);
    check("under_cnt", under_cnt, 32'd1);
    expect_rx("under", 16'hFFFF);

    // Abort after 7 bits, then a clean frame
    abort_cnt = 0;
    frame_start(16'hAAAA);
    shift_bits(16'hAAAA, 7, 1'b1, m0);
    gap();
    check("abort_cnt", abort_cnt, 32'd1);
    check("abort_rx_cnt", rx_q.size(), 32'd0);
    check("abort_miso_oe", {31'b0, miso_oe}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    rx_q.delete();
    push_tx(16'h3C5A);
    xfer(16'hC3C3, m0);
    check("post_abort_miso", {16'b0, m0}, 32'h3C5A);
    expect_rx("post_abort", 16'hC3C3);
    check("post_abort_aborts", abort_cnt, 32'd1);

    // Reset after 5 bits with csn held low
    abort_cnt = 0;
    push_tx(16'h7E81);
    frame_start(16'hFFFF);
    shift_bits(16'hFFFF, 5, 1'b0, m0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("midrst_miso_oe", {31'b0, miso_oe}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_tx_ready", {31'b0, tx_ready}, 32'd1);
    rx_q.delete();
    oe_seen = 1'b0;
    shift_bits(16'h5555, 11, 1'b1, m0);
    gap();
    check("midrst_rx_cnt", rx_q.size(), 32'd0);
    check("midrst_oe_seen", {31'b0, oe_seen}, 32'd0);
    check("midrst_aborts", abort_cnt, 32'd0);
    push_tx(16'h2DD2);
    xfer(16'h0F0F, m0);
    check("post_rst_miso", {16'b0, m0}, 32'h2DD2);
    expect_rx("post_rst", 16'h0F0F);

    // Random words at minimum sclk period and csn setup
    for (int k = 0; k < 100; k++) begin
      exp_tx = 16'($urandom);
      exp_rx = 16'($urandom);
      push_tx(exp_tx);
      xfer(exp_rx, m0);
      check("rand_miso", {16'b0, m0}, {16'b0, exp_tx});
      expect_rx("rand", exp_rx);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
